mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline register and write-back stage of the 32-bit pipelined MIPS core. It captures memory-stage results on the rising clock edge, extracts and extends load data, and drives the register file write port. The register file commits on the falling edge, so a value written back is readable by ID in the same cycle.

## Interface
Parameters:
- REG_WIDTH, 32: datapath width; only 32 is supported.
- ADDR_SIZE, 5: register index width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold current WB contents.
- flush  in  1  replace the captured instruction with a bubble.
- mem_valid  in  1  MEM slot holds a real instruction.
- mem_RegWrite  in  1  instruction writes a register.
- mem_MemtoReg  in  1  1 = write load data, 0 = write ALU result.
- mem_load_type  in  3  load_type_e: LB, LBU, LH, LHU, LW.
- mem_write_register  in  ADDR_SIZE  destination register.
- mem_alu_result  in  REG_WIDTH  ALU result or effective address.
- mem_read_data  in  REG_WIDTH  aligned 32-bit word from data memory.
- RegWrite  out  1  register file write enable.
- write_register  out  ADDR_SIZE  register file write index.
- write_data  out  REG_WIDTH  register file write data.
- wb_valid  out  1  WB slot holds a real instruction.
- misaligned  out  1  held load is misaligned; its write is suppressed.
- retired_count  out  32  instructions retired (only with RETIRE_COUNT_EN).

## Operation
- Pipeline register holds: valid, RegWrite, MemtoReg, load_type, write_register, alu_result, read_data.
- Rising-edge update priority:
  - flush → valid=0, RegWrite=0; other fields don't care.
  - else stall → hold all fields.
  - else capture all mem_* inputs.
- Load extraction is big-endian and uses alu_result[1:0] of the held instruction:
  - LB/LBU: select byte 0 = bits[31:24] … byte 3 = bits[7:0]; LB sign-extends, LBU zero-extends.
  - LH/LHU: half 0 = bits[31:16], half 2 = bits[15:0]; LH sign-extends, LHU zero-extends.
  - LW: full word.
- write_data = MemtoReg ? extracted load data : alu_result.
- misaligned = valid & MemtoReg & (LH/LHU with addr[0]=1, or LW with addr[1:0]≠0).
- RegWrite = valid & held RegWrite & (write_register≠0) & ~misaligned. Writes to $0 are never issued.
- write_register is passed through unchanged.

## Timing
- Latency: one cycle from mem_* inputs to WB outputs. The register file commits on the following falling edge.
- All outputs are combinational from the pipeline register. They change only after a rising edge or reset.
- Reset (async assert, released on the next clock edge): all fields 0, so RegWrite=0, wb_valid=0, misaligned=0, write_data=0, write_register=0, retired_count=0.
- Reset asserted mid-instruction: the instruction is dropped with no write. Any pending falling-edge write in that cycle sees RegWrite=0.
- stall and flush together: flush wins.
- A stalled instruction re-drives an identical write every cycle; this is idempotent.
- Unknown mem_load_type: treated as LW.

## Configuration
- RETIRE_COUNT_EN defined:
  - 32-bit retired_count increments on a rising edge when wb_valid=1 and stall=0, including misaligned loads.
  - Wraps from 0xFFFFFFFF to 0; reset to 0.
- RETIRE_COUNT_EN undefined: the retired_count port and counter are absent.

## Structure
- Shared package mips_pkg holds:
  - typedef enum logic [2:0] load_type_e {LB, LBU, LH, LHU, LW};
  - constant REG_ZERO = 0.
- Sub-module load_align (combinational): inputs word, addr[1:0] and load_type; outputs the extended data and the misaligned flag. The stage instantiates it once.

## Test plan
- Reset mid-stream with mem_valid=1, RegWrite=1, reg 5 → all outputs 0; no write to reg 5.
- ALU writeback with alu_result=0x12345678, reg 7, MemtoReg=0 → next cycle RegWrite=1, write_register=7, write_data=0x12345678.
- Loads with read_data=0x80FF7F01:
  - LB at addr 0 → 0xFFFFFF80.
  - LBU at addr 1 → 0x000000FF.
  - LH at addr 2 → 0x00007F01.
  - LHU at addr 0 → 0x000080FF.
  - LW → 0x80FF7F01.
- LW at addr 0x...2 → misaligned=1, RegWrite=0, wb_valid=1. Write to reg 0 with RegWrite=1 → RegWrite=0.
- stall for 3 cycles while inputs change → outputs frozen. stall+flush together → wb_valid=0, RegWrite=0 next cycle.
- With RETIRE_COUNT_EN:
  - 10 valid, unstalled instructions → retired_count=10.
  - Preload near wrap: 0xFFFFFFFF + 1 → 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 32-bit pipelined MIPS core.
//   load_type_e : load width/sign selector carried down the pipe
//   REG_ZERO    : index of the hard-wired zero register
package mips_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4
  } load_type_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/load_align.sv
// Big-endian load extraction for the write-back stage (combinational).
// Ports:
//   word       in  32  aligned word read from data memory
//   addr       in  2   low effective-address bits of the load
//   load_type  in  3   load_type_e encoding; unknown encodings behave as LW
//   data       out 32  extracted and sign/zero-extended load data
//   misaligned out 1   halfword at odd address or word at non-zero offset
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte 0 is the most significant byte.
  always_comb begin
    byte_sel = word[31:24];
    case (addr)
      2'd0: byte_sel = word[31:24];
      2'd1: byte_sel = word[23:16];
      2'd2: byte_sel = word[15:8];
      2'd3: byte_sel = word[7:0];
      default: byte_sel = word[31:24];
    endcase
  end

  assign half_sel = addr[1] ? word[15:0] : word[31:16];

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (load_type)
      LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LBU: data = {24'd0, byte_sel};
      LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LHU: begin
        data       = {16'd0, half_sel};
        misaligned = addr[0];
      end
      default: begin
        data       = word;
        misaligned = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage.
// Captures memory-stage results on the rising edge and drives the register
// file write port combinationally from the held instruction.
// Optional feature macro: RETIRE_COUNT_EN adds a 32-bit retired-instruction
// counter on port retired_count.
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   stall, flush        hold the WB slot / replace the captured instr with a bubble
//   mem_*               memory-stage instruction fields
//   RegWrite            register file write enable (never for $0 or misaligned)
//   write_register      register file write index
//   write_data          register file write data
//   wb_valid            WB slot holds a real instruction
//   misaligned          held load is misaligned; its write is suppressed
//   retired_count       retired instructions (RETIRE_COUNT_EN only)
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_RegWrite,
  input  logic                 mem_MemtoReg,
  input  logic [2:0]           mem_load_type,
  input  logic [ADDR_SIZE-1:0] mem_write_register,
  input  logic [REG_WIDTH-1:0] mem_alu_result,
  input  logic [REG_WIDTH-1:0] mem_read_data,
  output logic                 RegWrite,
  output logic [ADDR_SIZE-1:0] write_register,
  output logic [REG_WIDTH-1:0] write_data,
  output logic                 wb_valid,
  output logic                 misaligned
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]          retired_count
`endif
);

  logic                 valid_q;
  logic                 regwrite_q;
  logic                 memtoreg_q;
  logic [2:0]           load_type_q;  // raw encoding so unknown values reach load_align
  logic [ADDR_SIZE-1:0] wr_reg_q;
  logic [REG_WIDTH-1:0] alu_q;
  logic [REG_WIDTH-1:0] rd_q;

  // Flush only needs to kill valid/RegWrite; the payload is don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      load_type_q <= 3'd0;
      wr_reg_q    <= '0;
      alu_q       <= '0;
      rd_q        <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= mem_valid;
      regwrite_q  <= mem_RegWrite;
      memtoreg_q  <= mem_MemtoReg;
      load_type_q <= mem_load_type;
      wr_reg_q    <= mem_write_register;
      alu_q       <= mem_alu_result;
      rd_q        <= mem_read_data;
    end
  end

  logic [31:0] load_data;
  logic        load_mis;

  load_align u_load_align (
    .word       (rd_q),
    .addr       (alu_q[1:0]),
    .load_type  (load_type_q),
    .data       (load_data),
    .misaligned (load_mis)
  );

  assign misaligned     = valid_q & memtoreg_q & load_mis;
  assign write_data     = memtoreg_q ? load_data : alu_q;
  assign write_register = wr_reg_q;
  assign wb_valid       = valid_q;
  assign RegWrite       = valid_q & regwrite_q & (wr_reg_q != ADDR_SIZE'(REG_ZERO)) &
                          ~misaligned;

`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_q;

  // Misaligned loads still retire; they just do not write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else if (valid_q && !stall) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        mem_valid, mem_RegWrite, mem_MemtoReg;
  logic [2:0]  mem_load_type;
  logic [4:0]  mem_write_register;
  logic [31:0] mem_alu_result, mem_read_data;
  logic        RegWrite, wb_valid, misaligned;
  logic [4:0]  write_register;
  logic [31:0] write_data;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_count;
`endif

  mem_wb_stage #(.REG_WIDTH(32), .ADDR_SIZE(5)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall              (stall),
    .flush              (flush),
    .mem_valid          (mem_valid),
    .mem_RegWrite       (mem_RegWrite),
    .mem_MemtoReg       (mem_MemtoReg),
    .mem_load_type      (mem_load_type),
    .mem_write_register (mem_write_register),
    .mem_alu_result     (mem_alu_result),
    .mem_read_data      (mem_read_data),
    .RegWrite           (RegWrite),
    .write_register     (write_register),
    .write_data         (write_data),
    .wb_valid           (wb_valid),
    .misaligned         (misaligned)
`ifdef RETIRE_COUNT_EN
    ,
    .retired_count      (retired_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] rd;
    logic        e_rw;
    logic [31:0] e_data;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  localparam logic [31:0] RD = 32'h80FF7F01;

  vec_t vecs[16];
  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [4:0] wreg, input logic [31:0] alu, input logic [31:0] rd);
    mem_valid          = v;
    mem_RegWrite       = rw;
    mem_MemtoReg       = m2r;
    mem_load_type      = lt;
    mem_write_register = wreg;
    mem_alu_result     = alu;
    mem_read_data      = rd;
  endtask

  function automatic vec_t mk(input string name, input logic valid, input logic rw,
                              input logic m2r, input logic [2:0] lt, input logic [4:0] wreg,
                              input logic [31:0] alu, input logic e_rw,
                              input logic [31:0] e_data, input logic e_mis);
    vec_t v;
    v.name = name; v.valid = valid; v.rw = rw; v.m2r = m2r; v.lt = lt; v.wreg = wreg;
    v.alu = alu; v.rd = RD; v.e_rw = e_rw; v.e_data = e_data; v.e_valid = valid;
    v.e_mis = e_mis;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    vecs[0]  = mk("alu_wb",    1, 1, 0, LW,   7, 32'h12345678, 1, 32'h12345678, 0);
    vecs[1]  = mk("lb_a0",     1, 1, 1, LB,   1, 32'h00001000, 1, 32'hFFFFFF80, 0);
    vecs[2]  = mk("lbu_a1",    1, 1, 1, LBU,  2, 32'h00001001, 1, 32'h000000FF, 0);
    vecs[3]  = mk("lh_a2",     1, 1, 1, LH,   3, 32'h00001002, 1, 32'h00007F01, 0);
    vecs[4]  = mk("lhu_a0",    1, 1, 1, LHU,  4, 32'h00001000, 1, 32'h000080FF, 0);
    vecs[5]  = mk("lw_a0",     1, 1, 1, LW,   5, 32'h00001000, 1, 32'h80FF7F01, 0);
    vecs[6]  = mk("lw_mis",    1, 1, 1, LW,   6, 32'h00001002, 0, 32'h80FF7F01, 1);
    vecs[7]  = mk("reg0",      1, 1, 0, LW,   0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);
    vecs[8]  = mk("lb_a3",     1, 1, 1, LB,   8, 32'h00000003, 1, 32'h00000001, 0);
    vecs[9]  = mk("lbu_a2",    1, 1, 1, LBU,  9, 32'h00000002, 1, 32'h0000007F, 0);
    vecs[10] = mk("lh_a0",     1, 1, 1, LH,  10, 32'h00000000, 1, 32'hFFFF80FF, 0);
    vecs[11] = mk("lhu_a2",    1, 1, 1, LHU, 11, 32'h00000002, 1, 32'h00007F01, 0);
    vecs[12] = mk("lh_mis",    1, 1, 1, LH,  12, 32'h00000001, 0, 32'hFFFF80FF, 1);
    vecs[13] = mk("lt_unknown",1, 1, 1, 3'd7,13, 32'h00000000, 1, 32'h80FF7F01, 0);
    vecs[14] = mk("invalid",   0, 1, 0, LW,  14, 32'h00000055, 0, 32'h00000055, 0);
    vecs[15] = mk("no_rw",     1, 0, 0, LW,  15, 32'h00000066, 0, 32'h00000066, 0);

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);
    #12;
    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_write_register", 32'(write_register), 32'd0);
`ifdef RETIRE_COUNT_EN
    check("rst_retired", retired_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven single-cycle vectors through a scoreboard queue.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].lt, vecs[i].wreg, vecs[i].alu,
            vecs[i].rd);
      sb.push_back(vecs[i]);
      step();
      e = sb.pop_front();
      check({e.name, "_RegWrite"}, 32'(RegWrite), 32'(e.e_rw));
      check({e.name, "_write_register"}, 32'(write_register), 32'(e.wreg));
      check({e.name, "_write_data"}, write_data, e.e_data);
      check({e.name, "_wb_valid"}, 32'(wb_valid), 32'(e.e_valid));
      check({e.name, "_misaligned"}, 32'(misaligned), 32'(e.e_mis));
    end

    // Stall: outputs frozen for three cycles while inputs change.
    drive(1, 1, 0, LW, 5'd9, 32'h0000A5A5, RD);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, LB, 5'(20 + i), 32'h00000001 + 32'(i), 32'h11111111);
      step();
      check("stall_RegWrite", 32'(RegWrite), 32'd1);
      check("stall_write_register", 32'(write_register), 32'd9);
      check("stall_write_data", write_data, 32'h0000A5A5);
    end
    stall = 1'b0;
    drive(1, 1, 0, LW, 5'd17, 32'h00000777, RD);
    step();
    check("unstall_write_register", 32'(write_register), 32'd17);
    check("unstall_write_data", write_data, 32'h00000777);

    // stall + flush together: flush wins.
    stall = 1'b1; flush = 1'b1;
    drive(1, 1, 0, LW, 5'd18, 32'h00000888, RD);
    step();
    check("flush_stall_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_stall_RegWrite", 32'(RegWrite), 32'd0);
    stall = 1'b0; flush = 1'b0;
    step();
    check("post_flush_RegWrite", 32'(RegWrite), 32'd1);
    check("post_flush_write_register", 32'(write_register), 32'd18);

    // Reset asserted mid-instruction drops the write to reg 5.
    drive(1, 1, 0, LW, 5'd5, 32'h0BADBEEF, RD);
    step();
    check("pre_reset_RegWrite", 32'(RegWrite), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_RegWrite", 32'(RegWrite), 32'd0);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    check("midrst_write_data", write_data, 32'd0);
    check("midrst_write_register", 32'(write_register), 32'd0);
    check("midrst_misaligned", 32'(misaligned), 32'd0);
    drive(0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_RegWrite", 32'(RegWrite), 32'd0);

`ifdef RETIRE_COUNT_EN
    check("cnt_after_reset", retired_count, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, LW, 5'(i + 1), 32'(i), RD);
      step();
    end
    drive(0, 0, 0, LW, 5'd0, 32'd0, RD);
    step();
    check("cnt_ten", retired_count, 32'd10);
    drive(1, 1, 0, LW, 5'd3, 32'd1, RD);
    step();
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    check("cnt_preload", retired_count, 32'hFFFFFFFF);
    drive(0, 0, 0, LW, 5'd0, 32'd0, RD);
    step();
    check("cnt_wrap", retired_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
